mesh_wh_rr_node: RTL and testbench

Five-port 2D-mesh wormhole router node with per-input flit FIFOs, XY dimension-order routing, and per-output round-robin allocation with a wormhole lock. It is the parametrised successor of the static-priority mesh node. It adds:
- configurable buffer depth and field widths;
- single-flit packets;
- saturating hop-count update;
- registered, backpressured outputs.

One instance sits at each mesh coordinate. Neighbouring instances connect output k to the adjacent node's opposite input.

---
 rtl/mesh_wh_pkg.sv | 23 ++
 rtl/mesh_wh_out_alloc.sv | 82 ++++++++
 rtl/mesh_wh_rr_node.sv | 105 ++++++++++
 tb/tb_mesh_wh_rr_node.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mesh_wh_pkg.sv
// mesh_wh_pkg: flit ids, port indices and flit field helpers shared by the mesh wormhole node
package mesh_wh_pkg;
    localparam int NUM_PORTS = 5;
    localparam logic [1:0] FLIT_SINGLE = 2'b00;
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_BODY = 2'b10;
    localparam logic [1:0] FLIT_TAIL = 2'b11;
    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_NORTH = 3'd1;
    localparam logic [2:0] PORT_EAST = 3'd2;
    localparam logic [2:0] PORT_SOUTH = 3'd3;
    localparam logic [2:0] PORT_WEST = 3'd4;
    typedef enum logic {ALLOC_IDLE, ALLOC_LOCKED} alloc_state_e;
    function automatic int col_lsb(input int hop_w);
        return hop_w;
    endfunction
    function automatic int row_lsb(input int hop_w, input int col_w);
        return hop_w + col_w;
    endfunction
    function automatic int id_lsb(input int data_w);
        return data_w;
    endfunction
endpackage

// File: rtl/mesh_wh_out_alloc.sv
// mesh_wh_out_alloc: per-output round-robin allocator with wormhole lock and registered output slot
module mesh_wh_out_alloc
    import mesh_wh_pkg::*;
#(
    parameter int FLIT_W = 10,
    parameter int HOP_CNT_W = 4,
    parameter int ID_LO = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] head_vld,
    input  logic [FLIT_W-1:0]    head [NUM_PORTS],
    input  logic                 out_rdy,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [NUM_PORTS-1:0] lock,
    output logic [FLIT_W-1:0]    out_data,
    output logic                 out_vld
);
    alloc_state_e state_q, state_d;
    logic [2:0] owner_q, owner_d, rr_q, rr_d, sel, idx;
    logic [3:0] sum;
    logic found, can_load, load;
    logic [FLIT_W-1:0] load_flit;
    assign can_load = !out_vld || out_rdy;
    assign lock = state_q == ALLOC_LOCKED ? NUM_PORTS'(1) << owner_q : '0;
    always_comb begin
        gnt = '0;
        found = 1'b0;
        sel = owner_q;
        idx = '0;
        sum = '0;
        load = 1'b0;
        load_flit = head[owner_q];
        state_d = state_q;
        owner_d = owner_q;
        rr_d = rr_q;
        if (state_q == ALLOC_IDLE) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                sum = 4'(rr_q) + 4'(i);
                idx = 3'(sum >= 4'(NUM_PORTS) ? sum - 4'(NUM_PORTS) : sum);
                if (!found && req[idx]) begin
                    found = 1'b1;
                    sel = idx;
                end
            end
            if (found && can_load) begin
                gnt[sel] = 1'b1;
                load = 1'b1;
                load_flit = head[sel];
                if (~&load_flit[HOP_CNT_W-1:0])
                    load_flit[HOP_CNT_W-1:0] = load_flit[HOP_CNT_W-1:0] + 1'b1;
                state_d = head[sel][ID_LO +: 2] == FLIT_HEAD ? ALLOC_LOCKED : ALLOC_IDLE;
                owner_d = sel;
                rr_d = sel == 3'(NUM_PORTS - 1) ? '0 : sel + 3'd1;
            end
        end else if (head_vld[owner_q] && can_load) begin
            gnt[owner_q] = 1'b1;
            load = 1'b1;
            if (head[owner_q][ID_LO +: 2] == FLIT_TAIL) state_d = ALLOC_IDLE;
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ALLOC_IDLE;
            owner_q <= '0;
            rr_q <= '0;
            out_vld <= 1'b0;
            out_data <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q <= rr_d;
            if (load) begin
                out_vld <= 1'b1;
                out_data <= load_flit;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/mesh_wh_rr_node.sv
// mesh_wh_rr_node: five-port XY wormhole mesh router with input FIFOs and round-robin output allocation
module mesh_wh_rr_node
    import mesh_wh_pkg::*;
#(
    parameter int FLIT_DATA_W = 8,
    parameter int FLIT_ID_W = 2,
    parameter int HOP_CNT_W = 4,
    parameter int ROW_ADDR_W = 2,
    parameter int COL_ADDR_W = 2,
    parameter int ROW_CORD = 0,
    parameter int COL_CORD = 0,
    parameter int BUFFER_DEPTH_W = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [5*(FLIT_ID_W+FLIT_DATA_W)-1:0]  in_chan_data_i,
    input  logic [4:0]                            in_chan_data_vld_i,
    output logic [4:0]                            in_chan_rdy_o,
    output logic [5*(FLIT_ID_W+FLIT_DATA_W)-1:0]  out_chan_data_o,
    output logic [4:0]                            out_chan_data_vld_o,
    input  logic [4:0]                            out_chan_rdy_i,
    output logic [4:0]                            drop_o
);
    localparam int FLIT_W = FLIT_ID_W + FLIT_DATA_W;
    localparam int DEPTH = 2 ** BUFFER_DEPTH_W;
    localparam int COL_LO = col_lsb(HOP_CNT_W);
    localparam int ROW_LO = row_lsb(HOP_CNT_W, COL_ADDR_W);
    localparam int ID_LO = id_lsb(FLIT_DATA_W);
    if (FLIT_DATA_W != HOP_CNT_W + ROW_ADDR_W + COL_ADDR_W || FLIT_ID_W != 2) begin : g_bad_cfg
        $error("mesh_wh_rr_node: inconsistent flit field widths");
    end
    logic [FLIT_W-1:0] head [NUM_PORTS];
    logic [NUM_PORTS-1:0] head_vld, head_req, drop, pop, locked;
    logic [2:0] route [NUM_PORTS];
    logic [NUM_PORTS-1:0] req [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt [NUM_PORTS];
    logic [NUM_PORTS-1:0] lock [NUM_PORTS];
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
        logic [FLIT_W-1:0] mem [DEPTH];
        logic [BUFFER_DEPTH_W:0] wr_ptr, rd_ptr;
        logic [COL_ADDR_W-1:0] dcol;
        logic [ROW_ADDR_W-1:0] drow;
        logic [1:0] id;
        logic full, push;
        assign full = (wr_ptr ^ rd_ptr) == {1'b1, {BUFFER_DEPTH_W{1'b0}}};
        assign push = in_chan_data_vld_i[p] && !full;
        assign in_chan_rdy_o[p] = !full;
        assign head_vld[p] = wr_ptr != rd_ptr;
        assign head[p] = mem[rd_ptr[BUFFER_DEPTH_W-1:0]];
        assign id = head[p][ID_LO +: 2];
        assign dcol = head[p][COL_LO +: COL_ADDR_W];
        assign drow = head[p][ROW_LO +: ROW_ADDR_W];
        assign route[p] = int'(dcol) > COL_CORD ? PORT_EAST :
                          int'(dcol) < COL_CORD ? PORT_WEST :
                          int'(drow) > ROW_CORD ? PORT_SOUTH :
                          int'(drow) < ROW_CORD ? PORT_NORTH : PORT_LOCAL;
        // packet starts may only request; orphaned BODY/TAIL flits are discarded
        assign head_req[p] = head_vld[p] && (id == FLIT_HEAD || id == FLIT_SINGLE) && !locked[p];
        assign drop[p] = head_vld[p] && (id == FLIT_BODY || id == FLIT_TAIL) && !locked[p];
        always_ff @(posedge clk_i) begin
            if (push) mem[wr_ptr[BUFFER_DEPTH_W-1:0]] <= in_chan_data_i[FLIT_W*p +: FLIT_W];
        end
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop[p]) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
    assign drop_o = drop;
    always_comb begin
        locked = '0;
        for (int o = 0; o < NUM_PORTS; o++) locked = locked | lock[o];
    end
    always_comb begin
        pop = drop;
        for (int o = 0; o < NUM_PORTS; o++) pop = pop | gnt[o];
    end
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++)
            for (int p = 0; p < NUM_PORTS; p++)
                req[o][p] = head_req[p] && route[p] == 3'(o);
    end
    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        mesh_wh_out_alloc #(
            .FLIT_W(FLIT_W),
            .HOP_CNT_W(HOP_CNT_W),
            .ID_LO(ID_LO)
        ) u_alloc (
            .clk_i(clk_i),
            .rst_ni(rst_ni),
            .req(req[o]),
            .head_vld(head_vld),
            .head(head),
            .out_rdy(out_chan_rdy_i[o]),
            .gnt(gnt[o]),
            .lock(lock[o]),
            .out_data(out_chan_data_o[FLIT_W*o +: FLIT_W]),
            .out_vld(out_chan_data_vld_o[o])
        );
    end
endmodule

// File: tb/tb_mesh_wh_rr_node.sv
// tb_mesh_wh_rr_node: directed self-checking bench for the mesh wormhole node placed at (1,1)
module tb_mesh_wh_rr_node;
    localparam logic [1:0] S = 2'b00, H = 2'b01, B = 2'b10, T = 2'b11;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [49:0] in_data, out_data;
    logic [4:0] in_vld, in_rdy, out_vld, out_rdy, drop;
    int cmps = 0;
    int errs = 0;
    always #5 clk = ~clk;
    mesh_wh_rr_node #(.ROW_CORD(1), .COL_CORD(1)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .in_chan_data_i(in_data),
        .in_chan_data_vld_i(in_vld),
        .in_chan_rdy_o(in_rdy),
        .out_chan_data_o(out_data),
        .out_chan_data_vld_o(out_vld),
        .out_chan_rdy_i(out_rdy),
        .drop_o(drop)
    );
    function automatic logic [31:0] fl(input logic [1:0] id, input logic [1:0] row,
                                       input logic [1:0] col, input logic [3:0] hop);
        return {22'b0, id, row, col, hop};
    endfunction
    function automatic logic [31:0] od(input int o);
        return 32'(out_data[o*10 +: 10]);
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic put(input int p, input logic [31:0] f);
        in_data[p*10 +: 10] = f[9:0];
        in_vld[p] = 1'b1;
    endtask
    initial begin
        in_data = '0;
        in_vld = '0;
        out_rdy = '1;
        tick;
        tick;
        chk("rst_vld", 32'(out_vld), 32'h0);
        chk("rst_data", 32'(|out_data), 32'h0);
        chk("rst_drop", 32'(drop), 32'h0);
        rst_n = 1'b1;
        tick;
        chk("rst_rdy", 32'(in_rdy), 32'h1f);
        // local SINGLE to self: two-cycle latency, hop 3 -> 4
        put(0, fl(S, 1, 1, 3));
        tick;
        in_vld = '0;
        chk("single_wait", 32'(out_vld[0]), 32'h0);
        tick;
        chk("single_vld", 32'(out_vld[0]), 32'h1);
        chk("single_data", od(0), fl(S, 1, 1, 4));
        tick;
        chk("single_clear", 32'(out_vld), 32'h0);
        // west packet eastbound, hop incremented only on the head
        put(4, fl(H, 1, 3, 0));
        tick;
        put(4, fl(B, 2, 1, 5));
        tick;
        chk("wh_head", od(2), fl(H, 1, 3, 1));
        chk("wh_head_vld", 32'(out_vld[2]), 32'h1);
        put(4, fl(B, 0, 2, 9));
        tick;
        chk("wh_body1", od(2), fl(B, 2, 1, 5));
        chk("wh_nodrop", 32'(drop), 32'h0);
        put(4, fl(T, 3, 0, 7));
        tick;
        chk("wh_body2", od(2), fl(B, 0, 2, 9));
        in_vld = '0;
        tick;
        chk("wh_tail", od(2), fl(T, 3, 0, 7));
        tick;
        chk("wh_done", 32'(out_vld[2]), 32'h0);
        put(4, fl(S, 1, 2, 15));
        tick;
        in_vld = '0;
        tick;
        chk("free_sat", od(2), fl(S, 1, 2, 15));
        chk("free_vld", 32'(out_vld[2]), 32'h1);
        tick;
        // inputs 1 and 3 race for east with rr = 0
        put(1, fl(H, 0, 3, 2));
        put(3, fl(H, 2, 2, 6));
        tick;
        put(1, fl(B, 1, 1, 1));
        put(3, fl(B, 3, 3, 3));
        tick;
        chk("rr_h1", od(2), fl(H, 0, 3, 3));
        put(1, fl(T, 1, 1, 2));
        put(3, fl(T, 2, 2, 2));
        tick;
        chk("rr_b1", od(2), fl(B, 1, 1, 1));
        in_vld = '0;
        tick;
        chk("rr_t1", od(2), fl(T, 1, 1, 2));
        tick;
        chk("rr_h3", od(2), fl(H, 2, 2, 7));
        tick;
        chk("rr_b3", od(2), fl(B, 3, 3, 3));
        tick;
        chk("rr_t3", od(2), fl(T, 2, 2, 2));
        tick;
        chk("rr_idle", 32'(out_vld[2]), 32'h0);
        // rr now 4: input 4 beats input 0
        put(0, fl(S, 1, 3, 1));
        put(4, fl(S, 0, 2, 2));
        tick;
        in_vld = '0;
        tick;
        chk("rr4_first", od(2), fl(S, 0, 2, 3));
        tick;
        chk("rr4_second", od(2), fl(S, 1, 3, 2));
        tick;
        chk("rr4_idle", 32'(out_vld[2]), 32'h0);
        // output stall mid-packet
        put(4, fl(H, 1, 2, 0));
        tick;
        in_vld = '0;
        tick;
        chk("stall_head", od(2), fl(H, 1, 2, 1));
        out_rdy[2] = 1'b0;
        put(4, fl(B, 0, 1, 2));
        tick;
        chk("stall_rdy1", 32'(in_rdy[4]), 32'h1);
        put(4, fl(B, 1, 2, 3));
        tick;
        chk("stall_rdy2", 32'(in_rdy[4]), 32'h1);
        put(4, fl(B, 2, 3, 4));
        tick;
        chk("stall_rdy3", 32'(in_rdy[4]), 32'h1);
        put(4, fl(B, 3, 0, 5));
        tick;
        chk("stall_full", 32'(in_rdy[4]), 32'h0);
        put(4, fl(T, 0, 0, 8));
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("stall_hold", od(2), fl(H, 1, 2, 1));
            chk("stall_hold_vld", 32'(out_vld[2]), 32'h1);
        end
        chk("stall_still_full", 32'(in_rdy[4]), 32'h0);
        out_rdy[2] = 1'b1;
        tick;
        chk("stall_b0", od(2), fl(B, 0, 1, 2));
        chk("stall_rdy_back", 32'(in_rdy[4]), 32'h1);
        tick;
        in_vld = '0;
        chk("stall_b1", od(2), fl(B, 1, 2, 3));
        tick;
        chk("stall_b2", od(2), fl(B, 2, 3, 4));
        tick;
        chk("stall_b3", od(2), fl(B, 3, 0, 5));
        tick;
        chk("stall_tail", od(2), fl(T, 0, 0, 8));
        tick;
        chk("stall_idle", 32'(out_vld[2]), 32'h0);
        // orphan BODY on idle input 4
        put(4, fl(B, 1, 3, 0));
        tick;
        in_vld = '0;
        chk("drop_pulse", 32'(drop), 32'h10);
        chk("drop_no_out1", 32'(out_vld), 32'h0);
        tick;
        chk("drop_clear", 32'(drop), 32'h0);
        chk("drop_no_out2", 32'(out_vld), 32'h0);
        put(4, fl(H, 2, 1, 0));
        tick;
        put(4, fl(T, 0, 0, 1));
        tick;
        in_vld = '0;
        chk("south_head", od(3), fl(H, 2, 1, 1));
        chk("south_vld", 32'(out_vld[3]), 32'h1);
        tick;
        chk("south_tail", od(3), fl(T, 0, 0, 1));
        tick;
        // asynchronous reset in the middle of a locked packet
        put(4, fl(H, 1, 3, 0));
        tick;
        put(4, fl(B, 0, 0, 0));
        tick;
        in_vld = '0;
        chk("pre_rst_vld", 32'(out_vld[2]), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(out_vld), 32'h0);
        chk("arst_data", 32'(|out_data), 32'h0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("arst_rdy", 32'(in_rdy), 32'h1f);
        put(0, fl(H, 1, 2, 5));
        tick;
        put(0, fl(T, 1, 1, 1));
        tick;
        in_vld = '0;
        chk("arst_fresh_head", od(2), fl(H, 1, 2, 6));
        tick;
        chk("arst_fresh_tail", od(2), fl(T, 1, 1, 1));
        chk("arst_no_drop", 32'(drop), 32'h0);
        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
